// File: rtl/alu_status_flags.sv
`default_nettype none
// ============================================================================
//  Module      : alu_status_flags
//  Description : Status-flag unit for the W-bit ALU. It registers zero and
//                overflow flags, a sticky overflow state, a saturating
//                overflow counter and an overflow interrupt held until acked.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_status_flags #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*W-1:0]     res,
    input  logic [2:0]         Sel,
    input  logic               res_valid,
    input  logic               clr,
    input  logic               irq_ack,
    output logic               flag_zero,
    output logic               flag_ovf,
    output logic               flags_vld,
    output logic               ovf_sticky,
    output logic [CNT_W-1:0]   ovf_count,
    output logic               ovf_irq
);

    localparam logic [2:0]       c_OP_ADD   = 3'b000;
    localparam logic [2:0]       c_OP_SUB   = 3'b001;
    localparam logic [2:0]       c_OP_MUL   = 3'b010;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_CLEAR   = 1'b0,
        S_TRIPPED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_base;
    state_t             w_state_next;
    logic               r_flag_zero;
    logic               r_flag_ovf;
    logic               r_flags_vld;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_base;
    logic [CNT_W-1:0]   w_count_next;
    logic               r_irq;
    logic               w_irq_next;
    logic               w_ovf;
    logic               w_evt;
    logic               w_zero;

    always_comb begin
        w_ovf = 1'b0;
        case (Sel)
            c_OP_ADD: w_ovf = res[W];
            c_OP_SUB: w_ovf = res[W];
            c_OP_MUL: w_ovf = |res[2*W-1:W];
            default:  w_ovf = 1'b0;
        endcase
    end

    assign w_evt  = res_valid & w_ovf;
    assign w_zero = (res[W-1:0] == '0);

    // clr is applied before evt, so clr+evt re-enters TRIPPED from CLEAR and re-raises the irq.
    always_comb begin
        w_state_base = clr ? S_CLEAR : r_state;
        w_state_next = w_evt ? S_TRIPPED : w_state_base;

        w_count_base = clr ? '0 : r_count;
        w_count_next = w_count_base;
        if (w_evt && (w_count_base != c_CNT_MAX)) begin
            w_count_next = w_count_base + c_CNT_ONE;
        end

        w_irq_next = r_irq;
        if (clr || irq_ack) begin
            w_irq_next = 1'b0;
        end
        if (w_evt && (w_state_base == S_CLEAR)) begin
            w_irq_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_CLEAR;
            r_count     <= '0;
            r_irq       <= 1'b0;
            r_flag_zero <= 1'b0;
            r_flag_ovf  <= 1'b0;
            r_flags_vld <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_count_next;
            r_irq       <= w_irq_next;
            r_flags_vld <= res_valid;
            if (res_valid) begin
                r_flag_zero <= w_zero;
                r_flag_ovf  <= w_ovf;
            end
        end
    end

    assign flag_zero  = r_flag_zero;
    assign flag_ovf   = r_flag_ovf;
    assign flags_vld  = r_flags_vld;
    assign ovf_sticky = (r_state == S_TRIPPED);
    assign ovf_count  = r_count;
    assign ovf_irq    = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_alu_status_flags.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_status_flags
//  Description : Directed bench for alu_status_flags (W=4) with CNT_W=8 and
//                CNT_W=2 instances, checked against an in-bench model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_status_flags;

    localparam int W = 4;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, DIV = 3'b011,
                           ORO = 3'b101;

    logic           clk;
    logic           rst;
    logic [2*W-1:0] res;
    logic [2:0]     Sel;
    logic           res_valid;
    logic           clr;
    logic           irq_ack;

    logic       a_zero, a_ovf, a_vld, a_sticky, a_irq;
    logic [7:0] a_count;
    logic       b_zero, b_ovf, b_vld, b_sticky, b_irq;
    logic [1:0] b_count;

    int n_checks = 0;
    int n_pass   = 0;

    alu_status_flags #(.W(W), .CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .res(res), .Sel(Sel), .res_valid(res_valid),
        .clr(clr), .irq_ack(irq_ack), .flag_zero(a_zero), .flag_ovf(a_ovf),
        .flags_vld(a_vld), .ovf_sticky(a_sticky), .ovf_count(a_count), .ovf_irq(a_irq)
    );

    alu_status_flags #(.W(W), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .res(res), .Sel(Sel), .res_valid(res_valid),
        .clr(clr), .irq_ack(irq_ack), .flag_zero(b_zero), .flag_ovf(b_ovf),
        .flags_vld(b_vld), .ovf_sticky(b_sticky), .ovf_count(b_count), .ovf_irq(b_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the rules, one step per clock edge.
    typedef struct {
        int zero;
        int ovf;
        int vld;
        int sticky;
        int cnt8;
        int cnt2;
        int irq;
    } model_t;

    model_t m;

    function automatic int overflow_of(input int op, input int r);
        if (op == 0 || op == 1) return (r / 16) % 2;
        if (op == 2)            return (r / 16) != 0 ? 1 : 0;
        return 0;
    endfunction

    function automatic model_t model_step(input model_t s, input int v, input int op,
                                          input int r, input int c, input int ack);
        model_t n;
        int     ov;
        n  = s;
        ov = overflow_of(op, r);
        n.vld = v;
        if (v != 0) begin
            n.zero = (r % 16 == 0) ? 1 : 0;
            n.ovf  = ov;
        end
        if (c != 0) begin
            n.sticky = 0;
            n.cnt8   = 0;
            n.cnt2   = 0;
            n.irq    = 0;
        end else if (ack != 0) begin
            n.irq = 0;
        end
        if (v != 0 && ov != 0) begin
            if (n.sticky == 0) n.irq = 1;
            n.sticky = 1;
            if (n.cnt8 < 255) n.cnt8 = n.cnt8 + 1;
            if (n.cnt2 < 3)   n.cnt2 = n.cnt2 + 1;
        end
        return n;
    endfunction

    function automatic model_t model_reset();
        model_t z;
        z = '{0, 0, 0, 0, 0, 0, 0};
        return z;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m, int'(res_valid), int'(Sel), int'(res), int'(clr), int'(irq_ack));
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("m.zero8",   int'(a_zero),   m.zero);
            chk("m.ovf8",    int'(a_ovf),    m.ovf);
            chk("m.vld8",    int'(a_vld),    m.vld);
            chk("m.sticky8", int'(a_sticky), m.sticky);
            chk("m.count8",  int'(a_count),  m.cnt8);
            chk("m.irq8",    int'(a_irq),    m.irq);
            chk("m.zero2",   int'(b_zero),   m.zero);
            chk("m.ovf2",    int'(b_ovf),    m.ovf);
            chk("m.vld2",    int'(b_vld),    m.vld);
            chk("m.sticky2", int'(b_sticky), m.sticky);
            chk("m.count2",  int'(b_count),  m.cnt2);
            chk("m.irq2",    int'(b_irq),    m.irq);
        end
    end

    // Hand-computed expectations; ca/cb are the CNT_W=8 / CNT_W=2 counts.
    task automatic expect_all(input string t, input int z, input int o, input int v,
                              input int s, input int ca, input int cb, input int q);
        chk({t, ".zero"},   int'(a_zero),   z);
        chk({t, ".ovf"},    int'(a_ovf),    o);
        chk({t, ".vld"},    int'(a_vld),    v);
        chk({t, ".sticky"}, int'(a_sticky), s);
        chk({t, ".count8"}, int'(a_count),  ca);
        chk({t, ".count2"}, int'(b_count),  cb);
        chk({t, ".irq"},    int'(a_irq),    q);
        chk({t, ".irq2"},   int'(b_irq),    q);
    endtask

    task automatic cyc(input logic v, input logic [2:0] op, input logic [7:0] r,
                       input logic c, input logic ack);
        res_valid = v;
        Sel       = op;
        res       = r;
        clr       = c;
        irq_ack   = ack;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        clr       = 1'b0;
        irq_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; res = '0; Sel = '0; res_valid = 1'b0; clr = 1'b0; irq_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expect_all("reset", 0, 0, 0, 0, 0, 0, 0);

        cyc(1, MUL, 8'h0F, 0, 0); expect_all("mul15",  0, 0, 1, 0, 0, 0, 0);
        cyc(1, MUL, 8'h10, 0, 0); expect_all("mul16",  1, 1, 1, 1, 1, 1, 1);
        cyc(0, MUL, 8'h00, 0, 0); expect_all("idle",   1, 1, 0, 1, 1, 1, 1);
        cyc(1, ADD, 8'h10, 0, 0); expect_all("add8p8", 1, 1, 1, 1, 2, 2, 1);
        cyc(1, ORO, 8'hF0, 0, 0); expect_all("orF0",   1, 0, 1, 1, 2, 2, 1);
        cyc(1, SUB, 8'h1F, 0, 0); expect_all("subbrw", 0, 1, 1, 1, 3, 3, 1);
        cyc(1, DIV, 8'hFF, 0, 0); expect_all("divFF",  0, 0, 1, 1, 3, 3, 1);
        cyc(1, MUL, 8'h20, 0, 0); expect_all("mul20",  1, 1, 1, 1, 4, 3, 1);
        cyc(0, ADD, 8'h00, 0, 1); expect_all("ack",    1, 1, 0, 1, 4, 3, 0);
        cyc(0, ADD, 8'h00, 0, 1); expect_all("ack0",   1, 1, 0, 1, 4, 3, 0);
        cyc(0, ADD, 8'h00, 1, 0); expect_all("clr",    1, 1, 0, 0, 0, 0, 0);

        cyc(1, MUL, 8'h10, 0, 0); expect_all("sat1", 1, 1, 1, 1, 1, 1, 1);
        cyc(1, MUL, 8'h30, 0, 1); expect_all("sat2", 1, 1, 1, 1, 2, 2, 0);
        cyc(1, MUL, 8'h40, 0, 0); expect_all("sat3", 1, 1, 1, 1, 3, 3, 0);
        cyc(1, MUL, 8'h50, 0, 0); expect_all("sat4", 1, 1, 1, 1, 4, 3, 0);
        cyc(1, MUL, 8'h61, 0, 0); expect_all("sat5", 0, 1, 1, 1, 5, 3, 0);

        cyc(1, MUL, 8'h10, 1, 0); expect_all("clrevt", 1, 1, 1, 1, 1, 1, 1);
        cyc(0, ADD, 8'h00, 1, 0); expect_all("clr2",   1, 1, 0, 0, 0, 0, 0);
        cyc(1, MUL, 8'h10, 0, 1); expect_all("ackset", 1, 1, 1, 1, 1, 1, 1);

        for (int i = 0; i < 10; i++) cyc(0, MUL, 8'hFF, 0, 0);
        expect_all("novalid", 1, 1, 0, 1, 1, 1, 1);

        // Asynchronous reset asserted and checked between clock edges.
        #1 rst = 1'b1;
        #1 expect_all("arst", 0, 0, 0, 0, 0, 0, 0);
        chk("arst.sticky2", int'(b_sticky), 0);
        #1 rst = 1'b0;

        cyc(1, ADD, 8'h05, 0, 0); expect_all("post1", 0, 0, 1, 0, 0, 0, 0);
        cyc(1, SUB, 8'h10, 0, 0); expect_all("post2", 1, 1, 1, 1, 1, 1, 1);
        cyc(0, ADD, 8'h00, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
